// File: rtl/cacode_sweep_ctrl_if.sv
// Signal bundle between the PRN sweep scheduler, its requester/correlator side
// and the C/A code generator it steers.
interface cacode_sweep_ctrl_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic               abort;
   logic [5:0]         prn_first;
   logic [5:0]         prn_last;
   logic [DWELL_W-1:0] dwell;
   logic               chip_tick;
   logic               res_ack;
   logic               cacode_g2_init;
   logic [9:0]         cacode_init;
   logic               cacode_rd;
   logic [5:0]         prn;
   logic [9:0]         chip_idx;
   logic               epoch;
   logic               dwell_done;
   logic               busy;
   logic               sweep_done;
   logic               range_err;

   modport master (
      output start, abort, prn_first, prn_last, dwell, chip_tick, res_ack,
      input  cacode_g2_init, cacode_init, cacode_rd, prn, chip_idx, epoch,
             dwell_done, busy, sweep_done, range_err
   );

   modport slave (
      input  start, abort, prn_first, prn_last, dwell, chip_tick, res_ack,
      output cacode_g2_init, cacode_init, cacode_rd, prn, chip_idx, epoch,
             dwell_done, busy, sweep_done, range_err
   );
endinterface

// File: rtl/cacode_sweep_ctrl.sv
// PRN sweep scheduler: loads G2 taps per PRN, advances the C/A code for a
// programmed number of periods, then waits for the correlator to take the result.
module cacode_sweep_ctrl #(
   parameter int DWELL_W  = 8,
   parameter int CODE_LEN = 1023
) (
   input logic               clk,
   input logic               rst,
   cacode_sweep_ctrl_if.slave bus
);

   localparam logic [9:0] CHIP_MAX = 10'(CODE_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [5:0]         prn_q, prn_d;
   logic [5:0]         prn_last_q, prn_last_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] period_q, period_d;
   logic [9:0]         chip_idx_q, chip_idx_d;
   logic               epoch_q, epoch_d;
   logic               sweep_done_q, sweep_done_d;
   logic               range_err_q, range_err_d;
   logic               range_ok;

   // G2 tap pair {tap_a, tap_b} for each GPS PRN; tap 10 encodes as 4'hA.
   function automatic logic [7:0] tap_pair(input logic [5:0] p);
      case (p)
         6'd1:  tap_pair = 8'h26;  6'd2:  tap_pair = 8'h37;
         6'd3:  tap_pair = 8'h48;  6'd4:  tap_pair = 8'h59;
         6'd5:  tap_pair = 8'h19;  6'd6:  tap_pair = 8'h2A;
         6'd7:  tap_pair = 8'h18;  6'd8:  tap_pair = 8'h29;
         6'd9:  tap_pair = 8'h3A;  6'd10: tap_pair = 8'h23;
         6'd11: tap_pair = 8'h34;  6'd12: tap_pair = 8'h56;
         6'd13: tap_pair = 8'h67;  6'd14: tap_pair = 8'h78;
         6'd15: tap_pair = 8'h89;  6'd16: tap_pair = 8'h9A;
         6'd17: tap_pair = 8'h14;  6'd18: tap_pair = 8'h25;
         6'd19: tap_pair = 8'h36;  6'd20: tap_pair = 8'h47;
         6'd21: tap_pair = 8'h58;  6'd22: tap_pair = 8'h69;
         6'd23: tap_pair = 8'h13;  6'd24: tap_pair = 8'h46;
         6'd25: tap_pair = 8'h57;  6'd26: tap_pair = 8'h68;
         6'd27: tap_pair = 8'h79;  6'd28: tap_pair = 8'h8A;
         6'd29: tap_pair = 8'h16;  6'd30: tap_pair = 8'h27;
         6'd31: tap_pair = 8'h38;  6'd32: tap_pair = 8'h49;
         default: tap_pair = 8'h00;
      endcase
   endfunction

   assign range_ok = (bus.prn_first >= 6'd1) && (bus.prn_first <= 6'd32) &&
                     (bus.prn_last  >= 6'd1) && (bus.prn_last  <= 6'd32) &&
                     (bus.prn_first <= bus.prn_last);

   always_comb begin
      state_d      = state_q;
      prn_d        = prn_q;
      prn_last_d   = prn_last_q;
      dwell_d      = dwell_q;
      period_d     = period_q;
      chip_idx_d   = chip_idx_q;
      epoch_d      = 1'b0;
      sweep_done_d = 1'b0;
      range_err_d  = 1'b0;

      if (bus.abort) begin
         state_d    = S_IDLE;
         prn_d      = '0;
         chip_idx_d = '0;
         period_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (range_ok) begin
                     prn_d      = bus.prn_first;
                     prn_last_d = bus.prn_last;
                     dwell_d    = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                     state_d    = S_LOAD;
                  end else begin
                     range_err_d = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               chip_idx_d = '0;
               period_d   = '0;
               state_d    = S_RUN;
            end
            S_RUN: begin
               // The dwell is clamped to >=1, so the period count meets it before it can wrap.
               if (bus.chip_tick) begin
                  if (chip_idx_q == CHIP_MAX) begin
                     chip_idx_d = '0;
                     epoch_d    = 1'b1;
                     period_d   = period_q + DWELL_W'(1);
                     if (period_d == dwell_q) begin
                        state_d = S_HOLD;
                     end
                  end else begin
                     chip_idx_d = chip_idx_q + 10'd1;
                  end
               end
            end
            S_HOLD: begin
               if (bus.res_ack) begin
                  if (prn_q == prn_last_q) begin
                     state_d      = S_IDLE;
                     sweep_done_d = 1'b1;
                  end else begin
                     prn_d   = prn_q + 6'd1;
                     state_d = S_LOAD;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         prn_q        <= '0;
         prn_last_q   <= '0;
         dwell_q      <= '0;
         period_q     <= '0;
         chip_idx_q   <= '0;
         epoch_q      <= 1'b0;
         sweep_done_q <= 1'b0;
         range_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prn_q        <= prn_d;
         prn_last_q   <= prn_last_d;
         dwell_q      <= dwell_d;
         period_q     <= period_d;
         chip_idx_q   <= chip_idx_d;
         epoch_q      <= epoch_d;
         sweep_done_q <= sweep_done_d;
         range_err_q  <= range_err_d;
      end
   end

   // Only the chip-advance strobe is combinational, so the generator steps on the tick itself.
   assign bus.cacode_rd      = (state_q == S_RUN) && bus.chip_tick;
   assign bus.cacode_g2_init = (state_q == S_LOAD);
   assign bus.cacode_init    = (state_q != S_IDLE) ? {2'b00, tap_pair(prn_q)} : 10'd0;
   assign bus.prn            = prn_q;
   assign bus.chip_idx       = chip_idx_q;
   assign bus.epoch          = epoch_q;
   assign bus.dwell_done     = (state_q == S_HOLD);
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.sweep_done     = sweep_done_q;
   assign bus.range_err      = range_err_q;

endmodule

// File: tb/tb_cacode_sweep_ctrl.sv
// Directed bench for the PRN sweep scheduler: tap loads, dwell lengths,
// range rejection, abort and asynchronous reset behaviour.
module tb_cacode_sweep_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   rd_cnt;
   int   epoch_cnt;
   int   g2_cnt;
   int   sweep_cnt;
   int   rd_base;
   int   epoch_base;
   int   g2_base;
   int   sweep_base;

   cacode_sweep_ctrl_if #(.DWELL_W(8)) bus ();

   cacode_sweep_ctrl #(.DWELL_W(8), .CODE_LEN(1023)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters sampled mid-cycle, away from the active edge.
   initial begin
      rd_cnt = 0; epoch_cnt = 0; g2_cnt = 0; sweep_cnt = 0;
   end
   always @(negedge clk) begin
      if (rst) begin
         if (bus.cacode_rd)      rd_cnt++;
         if (bus.epoch)          epoch_cnt++;
         if (bus.cacode_g2_init) g2_cnt++;
         if (bus.sweep_done)     sweep_cnt++;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      rd_base = rd_cnt; epoch_base = epoch_cnt; g2_base = g2_cnt; sweep_base = sweep_cnt;
   endtask

   // Pulses start for one cycle; returns in the cycle after start was sampled.
   task automatic apply_stimulus(input logic [5:0] first, input logic [5:0] last, input logic [7:0] dw);
      bus.prn_first = first;
      bus.prn_last  = last;
      bus.dwell     = dw;
      bus.start     = 1'b1;
      step();
      bus.start     = 1'b0;
   endtask

   // Ticks every tick_per cycles until HOLD, then spends one more HOLD cycle with a tick applied.
   task automatic run_dwell(input int tick_per, input int budget);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < budget; k++) begin
         bus.chip_tick = ((k % tick_per) == 0);
         step();
         if (bus.dwell_done) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check_output("dwell_timeout", 32'd0, 32'd1);
      bus.chip_tick = 1'b1;
      step();
      bus.chip_tick = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check_output({tag, "_prn"}, 32'(bus.prn), 32'd0);
      check_output({tag, "_chip_idx"}, 32'(bus.chip_idx), 32'd0);
      check_output({tag, "_init"}, 32'(bus.cacode_init), 32'd0);
      check_output({tag, "_g2_init"}, 32'(bus.cacode_g2_init), 32'd0);
      check_output({tag, "_dwell_done"}, 32'(bus.dwell_done), 32'd0);
      check_output({tag, "_epoch"}, 32'(bus.epoch), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.chip_tick = 1'b0; bus.res_ack = 1'b0;
      bus.prn_first = 6'd0; bus.prn_last = 6'd0; bus.dwell = 8'd0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      check_output("reset_sweep_done", 32'(bus.sweep_done), 32'd0);
      check_output("reset_range_err", 32'(bus.range_err), 32'd0);
      check_output("reset_rd", 32'(bus.cacode_rd), 32'd0);
      rst = 1'b1;
      step();

      $display("[TB] single PRN 1, dwell 1, tick every 4");
      snap();
      apply_stimulus(6'd1, 6'd1, 8'd1);
      check_output("p1_g2_init", 32'(bus.cacode_g2_init), 32'd1);
      check_output("p1_init", 32'(bus.cacode_init), 32'h026);
      check_output("p1_busy", 32'(bus.busy), 32'd1);
      check_output("p1_prn", 32'(bus.prn), 32'd1);
      bus.chip_tick = 1'b1;
      #1;
      check_output("load_tick_rd", 32'(bus.cacode_rd), 32'd0);
      step();
      bus.chip_tick = 1'b0;
      check_output("load_tick_chip_idx", 32'(bus.chip_idx), 32'd0);
      check_output("p1_run_init", 32'(bus.cacode_init), 32'h026);
      run_dwell(4, 6000);
      check_output("p1_rd_count", 32'(rd_cnt - rd_base), 32'd1023);
      check_output("p1_epoch_count", 32'(epoch_cnt - epoch_base), 32'd1);
      check_output("p1_dwell_done", 32'(bus.dwell_done), 32'd1);
      check_output("hold_tick_chip_idx", 32'(bus.chip_idx), 32'd0);
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      check_output("p1_sweep_done", 32'(bus.sweep_done), 32'd1);
      check_output("p1_busy_end", 32'(bus.busy), 32'd0);
      check_output("p1_dwell_done_fall", 32'(bus.dwell_done), 32'd0);
      step();
      check_output("p1_sweep_done_pulse", 32'(bus.sweep_done), 32'd0);

      $display("[TB] range 3..4, dwell 2");
      snap();
      apply_stimulus(6'd3, 6'd4, 8'd2);
      check_output("p3_init", 32'(bus.cacode_init), 32'h048);
      check_output("p3_prn", 32'(bus.prn), 32'd3);
      run_dwell(2, 6000);
      check_output("p3_rd_count", 32'(rd_cnt - rd_base), 32'd2046);
      check_output("p3_epoch_count", 32'(epoch_cnt - epoch_base), 32'd2);
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      check_output("p4_g2_init", 32'(bus.cacode_g2_init), 32'd1);
      check_output("p4_init", 32'(bus.cacode_init), 32'h059);
      check_output("p4_prn", 32'(bus.prn), 32'd4);
      check_output("p4_sweep_done_early", 32'(bus.sweep_done), 32'd0);
      snap();
      run_dwell(2, 6000);
      check_output("p4_rd_count", 32'(rd_cnt - rd_base), 32'd2046);
      check_output("p4_epoch_count", 32'(epoch_cnt - epoch_base), 32'd2);
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      check_output("p4_sweep_done", 32'(bus.sweep_done), 32'd1);
      step();

      $display("[TB] invalid ranges");
      snap();
      apply_stimulus(6'd0, 6'd5, 8'd1);
      check_output("bad0_range_err", 32'(bus.range_err), 32'd1);
      check_output("bad0_busy", 32'(bus.busy), 32'd0);
      step();
      check_output("bad0_range_err_pulse", 32'(bus.range_err), 32'd0);
      apply_stimulus(6'd33, 6'd33, 8'd1);
      check_output("bad33_range_err", 32'(bus.range_err), 32'd1);
      check_output("bad33_busy", 32'(bus.busy), 32'd0);
      step();
      apply_stimulus(6'd5, 6'd2, 8'd1);
      check_output("bad52_range_err", 32'(bus.range_err), 32'd1);
      check_output("bad52_busy", 32'(bus.busy), 32'd0);
      step();
      check_output("bad_g2_count", 32'(g2_cnt - g2_base), 32'd0);

      $display("[TB] dwell 0 on PRN 32");
      snap();
      apply_stimulus(6'd32, 6'd32, 8'd0);
      check_output("p32_init", 32'(bus.cacode_init), 32'h049);
      run_dwell(2, 6000);
      check_output("p32_rd_count", 32'(rd_cnt - rd_base), 32'd1023);
      check_output("p32_epoch_count", 32'(epoch_cnt - epoch_base), 32'd1);
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
      check_output("p32_sweep_done", 32'(bus.sweep_done), 32'd1);
      step();

      $display("[TB] abort mid-RUN at chip 500");
      snap();
      apply_stimulus(6'd7, 6'd9, 8'd1);
      begin
         bit hit;
         hit = 1'b0;
         for (int k = 0; k < 3000; k++) begin
            bus.chip_tick = ((k % 2) == 0);
            step();
            if (bus.chip_idx == 10'd500) begin
               hit = 1'b1;
               break;
            end
         end
         if (!hit) check_output("abort_reach_timeout", 32'd0, 32'd1);
      end
      bus.chip_tick = 1'b0;
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_idle("abort_run");
      bus.chip_tick = 1'b1;
      #1;
      check_output("abort_run_rd", 32'(bus.cacode_rd), 32'd0);
      step();
      bus.chip_tick = 1'b0;
      check_output("abort_run_sweep", 32'(sweep_cnt - sweep_base), 32'd0);

      $display("[TB] abort together with res_ack");
      snap();
      apply_stimulus(6'd10, 6'd11, 8'd1);
      run_dwell(2, 6000);
      bus.abort = 1'b1;
      bus.res_ack = 1'b1;
      step();
      bus.abort = 1'b0;
      bus.res_ack = 1'b0;
      check_idle("abort_ack");
      check_output("abort_ack_sweep_done", 32'(bus.sweep_done), 32'd0);
      step();
      check_output("abort_ack_sweep_count", 32'(sweep_cnt - sweep_base), 32'd0);

      $display("[TB] abort together with start in IDLE");
      bus.abort = 1'b1;
      apply_stimulus(6'd1, 6'd1, 8'd1);
      bus.abort = 1'b0;
      check_output("abort_start_busy", 32'(bus.busy), 32'd0);
      check_output("abort_start_g2_init", 32'(bus.cacode_g2_init), 32'd0);
      check_output("abort_start_range_err", 32'(bus.range_err), 32'd0);

      $display("[TB] reset pulsed mid-HOLD");
      apply_stimulus(6'd20, 6'd20, 8'd1);
      run_dwell(2, 6000);
      check_output("pre_reset_dwell_done", 32'(bus.dwell_done), 32'd1);
      check_output("pre_reset_init", 32'(bus.cacode_init), 32'h047);
      #1;
      rst = 1'b0;
      #1;
      check_idle("async_reset");
      #1;
      rst = 1'b1;
      step();
      check_output("post_reset_busy", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cacode_sweep_ctrl.md
# cacode_sweep_ctrl

PRN sweep scheduler for the C/A code generator in the GNSS acquisition path. It walks a programmed range of GPS PRNs. For each PRN it:
- loads the generator's G2 tap selects,
- advances the code one chip per chip-rate tick for a programmed number of 1023-chip periods,
- holds until the downstream correlator acknowledges the dwell result.

It drives the CACODE generator's `g2_init`, `init` and `rd` inputs directly.

## Interface
Parameters:
- `DWELL_W`, 8: width of the dwell (code-period count) input.
- `CODE_LEN`, 1023: chips per code period.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `abort`  in  1  terminates any sweep; returns to IDLE.
- `prn_first`  in  6  first PRN, valid range 1..32.
- `prn_last`  in  6  last PRN, valid range 1..32.
- `dwell`  in  DWELL_W  code periods per PRN; 0 is treated as 1.
- `chip_tick`  in  1  chip-rate strobe, at most one cycle wide.
- `cacode_g2_init`  out  1  generator load strobe.
- `cacode_init`  out  10  tap selects: {2'b0, tap_a[3:0], tap_b[3:0]}.
- `cacode_rd`  out  1  generator chip-advance strobe.
- `prn`  out  6  PRN currently being dwelt on.
- `chip_idx`  out  10  chip index within the current period, 0..1022.
- `epoch`  out  1  one-cycle pulse at each period wrap.
- `dwell_done`  out  1  level; result ready for the current PRN.
- `res_ack`  in  1  correlator acknowledges `dwell_done`.
- `busy`  out  1  high in every state except IDLE.
- `sweep_done`  out  1  one-cycle pulse at normal sweep end.
- `range_err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, LOAD, RUN, HOLD.
- IDLE:
  - On `start`, prn_first and prn_last are checked: both must be 1..32 and prn_first ≤ prn_last.
  - If the range is valid, the block latches prn_first, prn_last and the effective dwell, then goes to LOAD.
  - If the range is invalid, `range_err` pulses and the block stays in IDLE.
- LOAD (exactly one cycle):
  - `cacode_init` = tap pair of `prn`; `cacode_g2_init` = 1.
  - `chip_idx` and the period counter clear.
  - Next state is RUN.
  - A `chip_tick` during LOAD is dropped, not forwarded.
- Tap table, PRN: a,b
  - PRNs 1–8: 1:2,6 2:3,7 3:4,8 4:5,9 5:1,9 6:2,10 7:1,8 8:2,9
  - PRNs 9–16: 9:3,10 10:2,3 11:3,4 12:5,6 13:6,7 14:7,8 15:8,9 16:9,10
  - PRNs 17–24: 17:1,4 18:2,5 19:3,6 20:4,7 21:5,8 22:6,9 23:1,3 24:4,6
  - PRNs 25–32: 25:5,7 26:6,8 27:7,9 28:8,10 29:1,6 30:2,7 31:3,8 32:4,9
- `cacode_init` holds the current PRN's pair in every state except IDLE. In IDLE it is 0.
- RUN:
  - `cacode_rd` = `chip_tick` (combinational, gated by state == RUN).
  - Each `rd` increments `chip_idx`. At 1022, `chip_idx` wraps to 0, `epoch` pulses and the period counter increments.
  - When the period counter reaches the effective dwell on a wrap, go to HOLD.
- HOLD:
  - `dwell_done` = 1; `cacode_rd` = 0.
  - On `res_ack`:
    - if `prn` == prn_last: go to IDLE and pulse `sweep_done`;
    - otherwise increment `prn` and go to LOAD.
  - `res_ack` outside HOLD is ignored.
- `abort` has priority in all states:
  - next state is IDLE;
  - no `sweep_done`;
  - all outputs return to their reset values.
  - `abort` with `res_ack` in the same cycle: abort wins.
  - `abort` with `start` in IDLE: `start` is ignored.
- Period counter width is DWELL_W. Because the dwell is clamped to ≥1, the counter cannot wrap.

## Timing
- Reset values:
  - state IDLE; `prn` = 0, `chip_idx` = 0.
  - `cacode_init` = 0; `cacode_g2_init` = 0; `cacode_rd` = 0.
  - `epoch`, `dwell_done`, `busy`, `sweep_done`, `range_err` = 0.
- `start` at cycle N: LOAD at N+1 (`g2_init` high); RUN from N+2; `busy` high from N+1.
- `cacode_rd` is zero-latency relative to `chip_tick`. All other outputs are registered.
- `epoch` is high in the cycle after the `rd` that wrapped `chip_idx`.
- `dwell_done` rises in the cycle after the final wrap and falls in the cycle after `res_ack`.
- Between PRNs, the gap from `res_ack` to the next LOAD is 1 cycle.
- `sweep_done` and `range_err` pulse in the cycle after the triggering event.
- Reset asserted mid-sweep: all state clears immediately and asynchronously.

## Test plan
- prn_first = prn_last = 1, dwell = 1, `chip_tick` every 4 cycles:
  - LOAD shows `cacode_init` = 10'h026;
  - exactly 1023 `rd` pulses and 1 `epoch`, then `dwell_done`;
  - `res_ack` → `sweep_done` pulse, `busy` low.
- Range 3..4, dwell = 2:
  - `cacode_init` is 10'h048, then 10'h059;
  - 2046 `rd` pulses and 2 `epoch` pulses per PRN;
  - `prn` is 3, then 4.
- Invalid starts: prn_first = 0, prn_first = 33, and prn_first = 5 with prn_last = 2:
  - each gives a `range_err` pulse;
  - state stays IDLE; no `g2_init`.
- dwell = 0 with PRN 32 → behaves as dwell = 1; `cacode_init` = 10'h049.
- `abort` mid-RUN at `chip_idx` = 500, and `abort` with `res_ack` in the same cycle:
  - IDLE next cycle; `rd` stops;
  - no `sweep_done`; all outputs at reset values.
- `chip_tick` during LOAD and HOLD → no `rd`; `chip_idx` unchanged. Reset pulsed mid-HOLD → immediate return to reset values.
